// File: rtl/down_counter_4_bit.sv
// Loadable down counter / interval timer with one-cycle terminal-count pulse
// and optional auto-reload for periodic tick generation.
module down_counter_4_bit #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             set,
  input  logic [WIDTH-1:0] in,
  input  logic             en,
  input  logic             reload_mode,
  output logic [WIDTH-1:0] out,
  output logic             tc,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] reload_val_q, reload_val_d;
  logic             tc_q, tc_d;
  logic             busy_q, busy_d;

  always_comb begin
    state_d      = state_q;
    out_d        = out_q;
    reload_val_d = reload_val_q;
    tc_d         = 1'b0;
    if (set) begin
      // A zero load parks in IDLE so it can never expire.
      out_d        = in;
      reload_val_d = in;
      state_d      = (in != '0) ? RUN : IDLE;
    end else if (state_q == RUN && en) begin
      if (out_q > WIDTH'(1)) begin
        out_d = out_q - WIDTH'(1);
      end else begin
        tc_d = 1'b1;
        if (reload_mode) begin
          out_d = reload_val_q;
        end else begin
          out_d   = '0;
          state_d = DONE;
        end
      end
    end
    busy_d = (state_d == RUN);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      out_q        <= '0;
      reload_val_q <= '0;
      tc_q         <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      out_q        <= out_d;
      reload_val_q <= reload_val_d;
      tc_q         <= tc_d;
      busy_q       <= busy_d;
    end
  end

  assign out  = out_q;
  assign tc   = tc_q;
  assign busy = busy_q;

endmodule
